free_addr_pool: RTL
===================

// Module: free_addr_pool
// PURPOSE
//  Free-list manager for the shared packet SRAM. Holds every unused cell address
//  in a circular free queue. Hands one address per cycle to the write path
//  (datasg.address_in) and takes back addresses released by the read path
//  once a cell has been read out. Sits directly upstream of datasg.
// PARAMETERS
//  address_width     12    width of one SRAM cell address
//  num_cells         4096  number of managed cells (<= 2**address_width)
//  almost_empty_lvl  16    almost_empty asserts when free_count <= this value
// PORTS
//  clk           in   1                clock, all logic on rising edge
//  rst           in   1                asynchronous reset, active-low
//  alloc_req     in   1                write path requests one free address
//  alloc_vld     out  1                alloc_addr valid this cycle (1-cycle pulse)
//  alloc_addr    out  address_width    allocated cell address
//  alloc_miss    out  1                request refused (pool empty or not initialised)
//  free_req      in   1                read path returns one address
//  free_addr     in   address_width    returned cell address
//  free_err      out  1                return dropped (pool already full), 1-cycle pulse
//  free_count    out  address_width+1  number of addresses currently in the pool
//  empty         out  1                free_count == 0
//  almost_empty  out  1                free_count <= almost_empty_lvl
//  init_done     out  1                high once the initial fill is complete
// BEHAVIOUR
//  - Reset (rst=0, async): state=INIT, init_cnt=0, rd_ptr=wr_ptr=0, free_count=0,
//    alloc_vld=0, alloc_addr=0, alloc_miss=0, free_err=0, init_done=0.
//    Reset asserted mid-operation discards the queue contents. All addresses
//    become free again after the next INIT.
//  - Storage: ring of num_cells x address_width. Pointers wrap num_cells-1 -> 0.
//  - FSM INIT: one cycle per address. Writes mem[init_cnt]=init_cnt and
//    increments init_cnt and free_count. When init_cnt reaches num_cells-1 it
//    writes the last entry and goes to RUN. wr_ptr is then 0 (wrapped),
//    free_count=num_cells, and init_done=1 from the next cycle.
//    INIT lasts exactly num_cells cycles.
//    In INIT: alloc_req -> alloc_miss=1 the next cycle. free_req is ignored
//    and free_err pulses.
//  - FSM RUN (stays until reset):
//    * alloc_req with free_count>0: next cycle alloc_vld=1, alloc_addr=mem[rd_ptr].
//      rd_ptr advances. Latency is 1 cycle. Back-to-back every-cycle requests
//      are supported.
//    * alloc_req with free_count==0 and no free_req: next cycle alloc_miss=1,
//      alloc_vld=0, alloc_addr holds its previous value.
//    * free_req with free_count<num_cells: mem[wr_ptr]=free_addr, wr_ptr advances.
//    * free_req with free_count==num_cells and no accepted alloc: dropped,
//      free_err=1 the next cycle.
//    * Simultaneous alloc_req and free_req, free_count>0: both are performed.
//      free_count is unchanged.
//    * Simultaneous alloc_req and free_req, free_count==0: bypass.
//      alloc_addr=free_addr, alloc_vld=1 the next cycle. Ring and free_count
//      are unchanged, and there is no miss.
//    * Simultaneous at free_count==num_cells: the alloc pops first, so the free
//      is accepted and free_err=0.
//  - free_count changes by -1 for an alloc only, +1 for a free only, 0 for both
//    or neither. It never goes below 0 or above num_cells.
//  - empty and almost_empty are combinational from the registered free_count.
//  - alloc_vld, alloc_miss and free_err are registered, single-cycle, mutually
//    consistent (never vld and miss together).
//  - Double-free is not detected. Callers guarantee each address is returned
//    once.
// TESTING
//  1 Release rst after 3 cycles -> init_done rises exactly 4096 cycles later,
//    free_count=4096, empty=0.
//  2 After init, alloc_req for 5 cycles -> alloc_vld 5 cycles, one cycle
//    delayed, addrs 0,1,2,3,4; free_count=4091.
//  3 Drain all 4096, then alloc_req alone -> alloc_miss=1, empty=1;
//    almost_empty=1 from free_count=16 down.
//  4 Pool empty, alloc_req+free_req(addr 0x2A5) same cycle -> alloc_vld=1,
//    alloc_addr=0x2A5, free_count stays 0.
//  5 Pool full, free_req(0x010) alone -> free_err=1, count 4096. With
//    alloc_req in the same cycle -> alloc_addr=0 (head), no free_err, count 4096.
//  6 Assert rst mid-run with free_count=100 -> all outputs reset
//    asynchronously; after release INIT repeats and addresses restart at 0.

Source files
------------

// File: rtl/free_addr_pool_if.sv
// free_addr_pool_if
//   Bundles the allocate/release handshakes and the pool status of
//   free_addr_pool.
//   slave  : seen by the pool (requests in, responses/status out)
//   master : seen by the write/read paths (requests out, responses/status in)
// Signals
//   alloc_req     write path asks for one free address
//   alloc_vld     alloc_addr valid (1-cycle pulse)
//   alloc_addr    allocated cell address
//   alloc_miss    request refused (pool empty or still initialising)
//   free_req      read path returns one address
//   free_addr     returned cell address
//   free_err      return dropped because the pool was full (1-cycle pulse)
//   free_count    addresses currently in the pool
//   empty         free_count == 0
//   almost_empty  free_count <= almost-empty level
//   init_done     initial fill complete
interface free_addr_pool_if #(
  parameter int ADDRESS_WIDTH = 12
);
  logic                     alloc_req;
  logic                     alloc_vld;
  logic [ADDRESS_WIDTH-1:0] alloc_addr;
  logic                     alloc_miss;
  logic                     free_req;
  logic [ADDRESS_WIDTH-1:0] free_addr;
  logic                     free_err;
  logic [ADDRESS_WIDTH:0]   free_count;
  logic                     empty;
  logic                     almost_empty;
  logic                     init_done;

  modport slave (
    input  alloc_req, free_req, free_addr,
    output alloc_vld, alloc_addr, alloc_miss, free_err,
           free_count, empty, almost_empty, init_done
  );

  modport master (
    output alloc_req, free_req, free_addr,
    input  alloc_vld, alloc_addr, alloc_miss, free_err,
           free_count, empty, almost_empty, init_done
  );
endinterface

// File: rtl/free_addr_pool.sv
// free_addr_pool
//   Free-list manager for the shared packet SRAM. Keeps every unused cell
//   address in a circular queue, hands one out per cycle to the write path
//   and takes back addresses released by the read path.
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous reset, active-low
//   io_bus   free_addr_pool_if.slave (alloc/free handshakes and status)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | filling the ring with 0..num_cells-1, one entry per cycle
// ST_RUN  | serving alloc/free requests until the next reset
module free_addr_pool #(
  parameter int ADDRESS_WIDTH    = 12,
  parameter int NUM_CELLS        = 4096,
  parameter int ALMOST_EMPTY_LVL = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  free_addr_pool_if.slave      io_bus
);

  localparam logic [ADDRESS_WIDTH-1:0] C_LAST = ADDRESS_WIDTH'(NUM_CELLS - 1);
  localparam logic [ADDRESS_WIDTH:0]   C_FULL = (ADDRESS_WIDTH + 1)'(NUM_CELLS);
  localparam logic [ADDRESS_WIDTH:0]   C_LVL  = (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_LVL);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_mem [0:NUM_CELLS-1];
  logic [ADDRESS_WIDTH-1:0] r_init_cnt;
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH:0]   r_free_count;
  logic                     r_alloc_vld;
  logic [ADDRESS_WIDTH-1:0] r_alloc_addr;
  logic                     r_alloc_miss;
  logic                     r_free_err;
  logic                     r_init_done;

  logic w_init_wr;
  logic w_pop;
  logic w_push;
  logic w_bypass;
  logic w_miss;
  logic w_ferr;

  function automatic logic [ADDRESS_WIDTH-1:0] f_inc(input logic [ADDRESS_WIDTH-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_bypass    = 1'b0;
    w_miss      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_wr = 1'b1;
        w_miss    = io_bus.alloc_req;
        w_ferr    = io_bus.free_req;
        if (r_init_cnt == C_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (io_bus.alloc_req) begin
          if (r_free_count != '0) begin
            // Pop happens first, so a same-cycle free always has room.
            w_pop  = 1'b1;
            w_push = io_bus.free_req;
          end else if (io_bus.free_req) begin
            // Empty pool: hand the returned address straight back out.
            w_bypass = 1'b1;
          end else begin
            w_miss = 1'b1;
          end
        end else if (io_bus.free_req) begin
          if (r_free_count != C_FULL) w_push = 1'b1;
          else                        w_ferr = 1'b1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_free_count <= '0;
      r_alloc_vld  <= 1'b0;
      r_alloc_addr <= '0;
      r_alloc_miss <= 1'b0;
      r_free_err   <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_alloc_vld  <= w_pop | w_bypass;
      r_alloc_miss <= w_miss;
      r_free_err   <= w_ferr;
      if (w_pop)         r_alloc_addr <= r_mem[r_rd_ptr];
      else if (w_bypass) r_alloc_addr <= io_bus.free_addr;
      // wr_ptr stays at 0 through INIT: the fill ends exactly where it wraps.
      if (w_init_wr) begin
        r_init_cnt   <= r_init_cnt + 1'b1;
        r_free_count <= r_free_count + 1'b1;
      end else if (w_push && !w_pop) begin
        r_free_count <= r_free_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_free_count <= r_free_count - 1'b1;
      end
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (r_state == ST_INIT && w_state_nxt == ST_RUN) r_init_done <= 1'b1;
    end
  end

  // Ring storage carries no reset; INIT rewrites every entry.
  always_ff @(posedge i_clk) begin
    if (w_init_wr)   r_mem[r_init_cnt] <= r_init_cnt;
    else if (w_push) r_mem[r_wr_ptr]   <= io_bus.free_addr;
  end

  assign io_bus.alloc_vld    = r_alloc_vld;
  assign io_bus.alloc_addr   = r_alloc_addr;
  assign io_bus.alloc_miss   = r_alloc_miss;
  assign io_bus.free_err     = r_free_err;
  assign io_bus.free_count   = r_free_count;
  assign io_bus.empty        = (r_free_count == '0);
  assign io_bus.almost_empty = (r_free_count <= C_LVL);
  assign io_bus.init_done    = r_init_done;

endmodule
